sodor_dmem_responder: RTL and testbench

- Data-memory responder for the Sodor core's dmem request port; the target end of the core-issued load/store protocol.
- Accepts one request at a time, holds it for a programmable latency, then commits stores or returns load data with a one-cycle response pulse.
- Sits beside the core in fuzzing tops as a variable-latency alternative to the zero-wait memory model, to expose core stall/response-handling bugs.

---
 rtl/sodor_dmem_responder.sv | 196 +++++++++++++++++++
 tb/tb_sodor_dmem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sodor_dmem_responder.sv
// Variable-latency data-memory responder for the Sodor dmem request port.
// Accepts one load/store at a time, holds it for LATENCY cycles, then pulses
// resp_valid_o with load data (or commits the store) and flags misaligned or
// illegal-typ requests on resp_err_o.
// Optional build macro SODOR_DMEM_LATENCY_JITTER_EN adds 0..3 extra wait
// cycles per request, drawn from an 8-bit LFSR.
module sodor_dmem_responder #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_data_i,
  input  logic            req_fcn_i,
  input  logic [2:0]      req_typ_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_data_o,
  output logic            resp_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned AW    = IDX_W + 2;
`ifdef SODOR_DMEM_LATENCY_JITTER_EN
  localparam int unsigned CNT_W = 6;
`else
  localparam int unsigned CNT_W = 4;
`endif

  localparam logic [2:0] TYP_B  = 3'd1;
  localparam logic [2:0] TYP_H  = 3'd2;
  localparam logic [2:0] TYP_W  = 3'd3;
  localparam logic [2:0] TYP_BU = 3'd5;
  localparam logic [2:0] TYP_HU = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rdy_q;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic [XLEN-1:0]  resp_data_q;
  logic [AW-1:0]    addr_q;
  logic [XLEN-1:0]  data_q;
  logic             fcn_q;
  logic [2:0]       typ_q;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             accept_c;
  logic [CNT_W-1:0] cnt_load_c;
  logic [AW-1:0]    cur_addr_c;
  logic [XLEN-1:0]  cur_data_c;
  logic             cur_fcn_c;
  logic [2:0]       cur_typ_c;
  logic             is_b_c, is_h_c, is_w_c, signed_c;
  logic             err_c;
  logic [31:0]      rd_word_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [XLEN-1:0]  ld_c;
  logic [XLEN-1:0]  resp_val_c;
  logic [31:0]      wr_word_c;
  logic             wr_en_c;
  logic             unused_addr_c;

  assign req_ready_o   = rdy_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_data_o   = resp_data_q;
  assign resp_err_o    = resp_err_q;
  assign unused_addr_c = ^req_addr_i[XLEN-1:AW];

  assign accept_c = (state_q == S_IDLE) && rdy_q && req_valid_i;

  // In IDLE the live request is on the ports (LATENCY=1 responds straight
  // from there); afterwards it is the latched copy.
  assign cur_addr_c = (state_q == S_IDLE) ? req_addr_i[AW-1:0] : addr_q;
  assign cur_data_c = (state_q == S_IDLE) ? req_data_i : data_q;
  assign cur_fcn_c  = (state_q == S_IDLE) ? req_fcn_i : fcn_q;
  assign cur_typ_c  = (state_q == S_IDLE) ? req_typ_i : typ_q;

  assign rd_word_c = mem_q[cur_addr_c[AW-1:2]];
  assign wr_en_c   = (state_q == S_RESP) && cur_fcn_c && !err_c;

`ifdef SODOR_DMEM_LATENCY_JITTER_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR (taps 8,6,5,4), stepped once per accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else if (accept_c) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign cnt_load_c = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
  assign cnt_load_c = CNT_W'(LATENCY - 1);
`endif

  // Size/alignment decode, load lane extraction and store byte-lane merge
  always_comb begin
    is_b_c     = (cur_typ_c == TYP_B) || (cur_typ_c == TYP_BU);
    is_h_c     = (cur_typ_c == TYP_H) || (cur_typ_c == TYP_HU);
    is_w_c     = (cur_typ_c == TYP_W);
    signed_c   = (cur_typ_c == TYP_B) || (cur_typ_c == TYP_H);
    err_c      = !(is_b_c || is_h_c || is_w_c) ||
                 (is_h_c && cur_addr_c[0]) ||
                 (is_w_c && (cur_addr_c[1:0] != 2'b00));
    byte_c     = rd_word_c[{cur_addr_c[1:0], 3'b000} +: 8];
    half_c     = rd_word_c[{cur_addr_c[1], 4'b0000} +: 16];
    ld_c       = '0;
    wr_word_c  = rd_word_c;
    if (is_b_c) begin
      ld_c = signed_c ? {{(XLEN-8){byte_c[7]}}, byte_c} : {{(XLEN-8){1'b0}}, byte_c};
      wr_word_c[{cur_addr_c[1:0], 3'b000} +: 8] = cur_data_c[7:0];
    end else if (is_h_c) begin
      ld_c = signed_c ? {{(XLEN-16){half_c[15]}}, half_c} : {{(XLEN-16){1'b0}}, half_c};
      wr_word_c[{cur_addr_c[1], 4'b0000} +: 16] = cur_data_c[15:0];
    end else if (is_w_c) begin
      ld_c      = XLEN'(rd_word_c);
      wr_word_c = cur_data_c[31:0];
    end
    resp_val_c = (err_c || cur_fcn_c) ? '0 : ld_c;
  end

  // Request FSM: accept, count down the latency, emit the response pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rdy_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      fcn_q        <= 1'b0;
      typ_q        <= 3'd0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      case (state_q)
        S_IDLE: begin
          rdy_q <= 1'b1;
          if (accept_c) begin
            addr_q <= req_addr_i[AW-1:0];
            data_q <= req_data_i;
            fcn_q  <= req_fcn_i;
            typ_q  <= req_typ_i;
            cnt_q  <= cnt_load_c;
            rdy_q  <= 1'b0;
            if (cnt_load_c == '0) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= err_c;
              resp_data_q  <= resp_val_c;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_c;
            resp_data_q  <= resp_val_c;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  // Scratchpad: stores commit on the edge that ends the response cycle
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[cur_addr_c[AW-1:2]] <= wr_word_c;
    end
  end

endmodule

// File: tb/tb_sodor_dmem_responder.sv
// Self-checking bench for sodor_dmem_responder: directed vector table,
// reset-during-request sequence and randomized traffic against a byte-level
// reference memory.
`timescale 1ns/1ps
module tb_sodor_dmem_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_fcn;
  logic [2:0]  req_typ;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  always #5 clk = ~clk;

  sodor_dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_fcn_i    (req_fcn),
    .req_typ_i    (req_typ),
    .resp_valid_o (resp_valid),
    .resp_data_o  (resp_data),
    .resp_err_o   (resp_err)
  );

  int unsigned pass_cnt = 0;
  int unsigned tot_cnt  = 0;

  logic [7:0] ref_mem [4096];
  logic [7:0] ref_lfsr;

  typedef struct {
    logic        fcn;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Byte-addressed memory model: applies a request, returns expected response
  function automatic void ref_access(input logic fcn, input logic [2:0] typ,
                                     input logic [31:0] addr, input logic [31:0] data,
                                     output logic [31:0] rdata, output logic err);
    int     size;
    int     base;
    longint v;
    case (typ)
      3'd1, 3'd5: size = 1;
      3'd2, 3'd6: size = 2;
      3'd3:       size = 4;
      default:    size = 0;
    endcase
    rdata = 32'h0;
    if (size == 0) err = 1'b1;
    else           err = ((addr % size) != 0);
    if (err) return;
    base = int'(addr % 4096);
    if (fcn) begin
      for (int i = 0; i < size; i++) ref_mem[base + i] = 8'(data >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v += longint'(ref_mem[base + i]) << (8 * i);
      if ((typ == 3'd1 || typ == 3'd2) && v >= (longint'(1) << (8 * size - 1)))
        v -= longint'(1) << (8 * size);
      rdata = 32'(v);
    end
  endfunction

  // Issue one request, wait for its response; checks latency and pulse shape
  task automatic do_req(input logic fcn, input logic [2:0] typ,
                        input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic err,
                        output logic [31:0] exp_d, output logic exp_e, output int lat);
    int n;
    int exp_lat;
    @(negedge clk);
    req_valid = 1'b1; req_fcn = fcn; req_typ = typ; req_addr = addr; req_data = data;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    rdata = 32'h0; err = 1'b0; lat = -1; exp_d = 32'h0; exp_e = 1'b0;
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
`ifdef SODOR_DMEM_LATENCY_JITTER_EN
    exp_lat  = int'(LAT) + int'(ref_lfsr[1:0]);
    ref_lfsr = {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
`else
    exp_lat = int'(LAT);
`endif
    ref_access(fcn, typ, addr, data, exp_d, exp_e);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 40);
    if (!resp_valid) begin
      chk("resp_timeout", 32'(resp_valid), 32'd1);
      return;
    end
    rdata = resp_data;
    err   = resp_err;
    chk("latency", 32'(lat), 32'(exp_lat));
    @(negedge clk);
    chk("pulse_one_cycle", 32'(resp_valid), 32'd0);
    chk("ready_after_resp", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd, ed, wd, ad;
    logic        re, ee, f;
    logic [2:0]  t;
    int          lat;

    tv[0]  = '{1'b1, 3'd3, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
    tv[1]  = '{1'b0, 3'd3, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0};
    tv[2]  = '{1'b0, 3'd1, 32'h0000_0013, 32'h0,        32'hFFFFFFDE, 1'b0};
    tv[3]  = '{1'b0, 3'd5, 32'h0000_0013, 32'h0,        32'h000000DE, 1'b0};
    tv[4]  = '{1'b0, 3'd2, 32'h0000_0012, 32'h0,        32'hFFFFDEAD, 1'b0};
    tv[5]  = '{1'b0, 3'd6, 32'h0000_0010, 32'h0,        32'h0000BEEF, 1'b0};
    tv[6]  = '{1'b1, 3'd1, 32'h0000_0011, 32'h55,       32'h0000_0000, 1'b0};
    tv[7]  = '{1'b0, 3'd3, 32'h0000_0010, 32'h0,        32'hDEAD55EF, 1'b0};
    tv[8]  = '{1'b1, 3'd2, 32'h0000_0012, 32'h1234,     32'h0000_0000, 1'b0};
    tv[9]  = '{1'b0, 3'd3, 32'h0000_0010, 32'h0,        32'h123455EF, 1'b0};
    tv[10] = '{1'b0, 3'd3, 32'h0000_0012, 32'h0,        32'h0000_0000, 1'b1};
    tv[11] = '{1'b1, 3'd2, 32'h0000_0011, 32'hFFFF,     32'h0000_0000, 1'b1};
    tv[12] = '{1'b0, 3'd3, 32'h0000_0010, 32'h0,        32'h123455EF, 1'b0};
    tv[13] = '{1'b0, 3'd4, 32'h0000_0010, 32'h0,        32'h0000_0000, 1'b1};
    tv[14] = '{1'b1, 3'd3, 32'h0000_1010, 32'hA5A5A5A5, 32'h0000_0000, 1'b0};
    tv[15] = '{1'b0, 3'd3, 32'h0000_0010, 32'h0,        32'hA5A5A5A5, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_fcn = 1'b0; req_typ = 3'd0;
    req_addr = 32'h0; req_data = 32'h0;
    ref_lfsr = 8'hA5;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Give the first 64 words known contents
    for (int w = 0; w < 64; w++) begin
      wd = (w == 8) ? 32'hCAFEF00D : $urandom;
      do_req(1'b1, 3'd3, 32'(w * 4), wd, rd, re, ed, ee, lat);
      chk("init_wr_err", 32'(re), 32'd0);
    end

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      do_req(tv[i].fcn, tv[i].typ, tv[i].addr, tv[i].data, rd, re, ed, ee, lat);
      chk($sformatf("tv%0d_data", i), rd, tv[i].exp_data);
      chk($sformatf("tv%0d_err", i), 32'(re), 32'(tv[i].exp_err));
    end

    // Reset while a write is pending: dropped, no response, no commit
    @(negedge clk);
    chk("midrst_ready_pre", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_fcn = 1'b1; req_typ = 3'd3; req_addr = 32'h20; req_data = 32'h1;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    ref_lfsr = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", 32'(resp_valid), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_resp_after", 32'(resp_valid), 32'd0);
    end
    chk("midrst_ready_post", 32'(req_ready), 32'd1);
    do_req(1'b0, 3'd3, 32'h20, 32'h0, rd, re, ed, ee, lat);
    chk("midrst_read_old", rd, 32'hCAFEF00D);
    chk("midrst_read_model", rd, ed);

`ifdef SODOR_DMEM_LATENCY_JITTER_EN
    // Back-to-back reads: latency follows LFSR model and stays in range
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 3'd3, 32'(i * 4), 32'h0, rd, re, ed, ee, lat);
      chk("jitter_lat_range", 32'((lat >= 2) && (lat <= 5)), 32'd1);
      chk("jitter_read", rd, ed);
    end
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      f  = 1'($urandom_range(0, 1));
      t  = 3'($urandom_range(0, 7));
      ad = $urandom & 32'hFFFF_F0FF;
      wd = $urandom;
      do_req(f, t, ad, wd, rd, re, ed, ee, lat);
      chk($sformatf("rnd%0d_data", i), rd, ed);
      chk($sformatf("rnd%0d_err", i), 32'(re), 32'(ee));
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
